// File: rtl/decode_stage_pkg.sv
// Shared RV32I globals: opcode constants, the 5-bit ALU/branch operator codes
// and the decoded-entry record held by the decode pipeline register.
package decode_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Branch comparisons sit in the upper half so the ALU can tell them apart by bit 4.
    typedef enum logic [4:0] {
        ALU_ADD             = 5'd0,
        ALU_SUB             = 5'd1,
        ALU_LSL             = 5'd2,
        ALU_SLT_SIGN        = 5'd3,
        ALU_SLT_UNSIGN      = 5'd4,
        ALU_XOR             = 5'd5,
        ALU_LSR_UNSIGN      = 5'd6,
        ALU_LSR_SIGN        = 5'd7,
        ALU_OR              = 5'd8,
        ALU_AND             = 5'd9,
        ALU_PASSTHROUGH_RS1 = 5'd10,
        ALU_PASSTHROUGH_RS2 = 5'd11,
        ALU_BR_EQ           = 5'd16,
        ALU_BR_NE           = 5'd17,
        ALU_BR_LTS          = 5'd18,
        ALU_BR_GES          = 5'd19,
        ALU_BR_LTU          = 5'd20,
        ALU_BR_GEU          = 5'd21
    } alu_op_e;

    typedef struct packed {
        alu_op_e     alu_op;
        logic        op1_pc;
        logic        op2_imm;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [2:0]  funct3;
        logic [31:0] pc;
    } dec_entry_t;

    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_LSL;
            3'b010:  op = ALU_SLT_SIGN;
            3'b011:  op = ALU_SLT_UNSIGN;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_LSR_SIGN : ALU_LSR_UNSIGN;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator; the format is chosen from the opcode
// and every immediate is sign-extended from instr[31].
module imm_gen
    import decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic [6:0] opcode;
    assign opcode = instr[6:0];

    always_comb begin
        imm = '0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word captured into a
// one-entry pipeline register with valid/ready handshakes on both sides.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic        o_dec_valid,
    input  logic        i_dec_ready,
    output logic [4:0]  o_alu_operator,
    output logic        o_op1_pc,
    output logic        o_op2_imm,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    output logic [4:0]  o_rd_addr,
    output logic        o_rd_we,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic        o_branch,
    output logic        o_jump,
    output logic        o_illegal,
    output logic [2:0]  o_funct3,
    output logic [31:0] o_pc
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_w;
    logic        legal;
    logic        writes_rd;
    logic        fetch_xfer;
    logic        valid_q;
    dec_entry_t  dec_d;
    dec_entry_t  dec_q;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    imm_gen u_imm_gen (
        .instr (i_instr),
        .imm   (imm_w)
    );

    always_comb begin
        dec_d          = '0;
        dec_d.imm      = imm_w;
        dec_d.rs1_addr = i_instr[19:15];
        dec_d.rs2_addr = i_instr[24:20];
        dec_d.rd_addr  = i_instr[11:7];
        dec_d.funct3   = funct3;
        dec_d.pc       = i_pc;
        dec_d.alu_op   = ALU_ADD;
        legal          = 1'b1;
        writes_rd      = 1'b0;

        case (opcode)
            OPC_OP: begin
                writes_rd = 1'b1;
                if (funct7 == FUNCT7_BASE)
                    dec_d.alu_op = alu_from_funct(funct3, 1'b0);
                else if (funct7 == FUNCT7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))
                    dec_d.alu_op = alu_from_funct(funct3, 1'b1);
                else
                    legal = 1'b0;
            end
            OPC_OP_IMM: begin
                writes_rd     = 1'b1;
                dec_d.op2_imm = 1'b1;
                // Only the shift forms carry a funct7 field; elsewhere those bits are immediate.
                case (funct3)
                    3'b001: begin
                        if (funct7 == FUNCT7_BASE) dec_d.alu_op = ALU_LSL;
                        else                       legal = 1'b0;
                    end
                    3'b101: begin
                        if (funct7 == FUNCT7_BASE)     dec_d.alu_op = ALU_LSR_UNSIGN;
                        else if (funct7 == FUNCT7_ALT) dec_d.alu_op = ALU_LSR_SIGN;
                        else                           legal = 1'b0;
                    end
                    default: dec_d.alu_op = alu_from_funct(funct3, 1'b0);
                endcase
            end
            OPC_LUI: begin
                writes_rd     = 1'b1;
                dec_d.alu_op  = ALU_PASSTHROUGH_RS2;
                dec_d.op2_imm = 1'b1;
            end
            OPC_AUIPC: begin
                writes_rd     = 1'b1;
                dec_d.op1_pc  = 1'b1;
                dec_d.op2_imm = 1'b1;
            end
            OPC_JAL: begin
                writes_rd     = 1'b1;
                dec_d.jump    = 1'b1;
                dec_d.op1_pc  = 1'b1;
                dec_d.op2_imm = 1'b1;
            end
            OPC_JALR: begin
                writes_rd     = 1'b1;
                dec_d.jump    = 1'b1;
                dec_d.op2_imm = 1'b1;
                if (funct3 != 3'b000) legal = 1'b0;
            end
            OPC_BRANCH: begin
                dec_d.branch = 1'b1;
                case (funct3)
                    3'b000:  dec_d.alu_op = ALU_BR_EQ;
                    3'b001:  dec_d.alu_op = ALU_BR_NE;
                    3'b100:  dec_d.alu_op = ALU_BR_LTS;
                    3'b101:  dec_d.alu_op = ALU_BR_GES;
                    3'b110:  dec_d.alu_op = ALU_BR_LTU;
                    3'b111:  dec_d.alu_op = ALU_BR_GEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                writes_rd     = 1'b1;
                dec_d.mem_rd  = 1'b1;
                dec_d.op2_imm = 1'b1;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) legal = 1'b0;
            end
            OPC_STORE: begin
                dec_d.mem_wr  = 1'b1;
                dec_d.op2_imm = 1'b1;
                if (funct3 > 3'b010) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec_d.alu_op  = ALU_PASSTHROUGH_RS1;
            dec_d.op1_pc  = 1'b0;
            dec_d.op2_imm = 1'b0;
            dec_d.mem_rd  = 1'b0;
            dec_d.mem_wr  = 1'b0;
            dec_d.branch  = 1'b0;
            dec_d.jump    = 1'b0;
            dec_d.illegal = 1'b1;
        end
        dec_d.rd_we = writes_rd && legal && (dec_d.rd_addr != 5'd0);
    end

    assign o_instr_ready = !valid_q || i_dec_ready;
    assign fetch_xfer    = i_instr_valid && o_instr_ready;

    // Reset beats flush, flush beats any transfer; an idle entry holds its outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (fetch_xfer) begin
            valid_q <= 1'b1;
            dec_q   <= dec_d;
        end else if (valid_q && i_dec_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_dec_valid    = valid_q;
    assign o_alu_operator = dec_q.alu_op;
    assign o_op1_pc       = dec_q.op1_pc;
    assign o_op2_imm      = dec_q.op2_imm;
    assign o_imm          = dec_q.imm;
    assign o_rs1_addr     = dec_q.rs1_addr;
    assign o_rs2_addr     = dec_q.rs2_addr;
    assign o_rd_addr      = dec_q.rd_addr;
    assign o_rd_we        = dec_q.rd_we;
    assign o_mem_rd       = dec_q.mem_rd;
    assign o_mem_wr       = dec_q.mem_wr;
    assign o_branch       = dec_q.branch;
    assign o_jump         = dec_q.jump;
    assign o_illegal      = dec_q.illegal;
    assign o_funct3       = dec_q.funct3;
    assign o_pc           = dec_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-decoded RV32I words checked one cycle
// after transfer, plus handshake, backpressure, flush and reset scenarios.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_instr_valid;
    logic        o_instr_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        i_flush;
    logic        o_dec_valid;
    logic        i_dec_ready;
    logic [4:0]  o_alu_operator;
    logic        o_op1_pc;
    logic        o_op2_imm;
    logic [31:0] o_imm;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic [4:0]  o_rd_addr;
    logic        o_rd_we;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic        o_branch;
    logic        o_jump;
    logic        o_illegal;
    logic [2:0]  o_funct3;
    logic [31:0] o_pc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    decode_stage dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_instr_valid  (i_instr_valid),
        .o_instr_ready  (o_instr_ready),
        .i_instr        (i_instr),
        .i_pc           (i_pc),
        .i_flush        (i_flush),
        .o_dec_valid    (o_dec_valid),
        .i_dec_ready    (i_dec_ready),
        .o_alu_operator (o_alu_operator),
        .o_op1_pc       (o_op1_pc),
        .o_op2_imm      (o_op2_imm),
        .o_imm          (o_imm),
        .o_rs1_addr     (o_rs1_addr),
        .o_rs2_addr     (o_rs2_addr),
        .o_rd_addr      (o_rd_addr),
        .o_rd_we        (o_rd_we),
        .o_mem_rd       (o_mem_rd),
        .o_mem_wr       (o_mem_wr),
        .o_branch       (o_branch),
        .o_jump         (o_jump),
        .o_illegal      (o_illegal),
        .o_funct3       (o_funct3),
        .o_pc           (o_pc)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_flush = 1'b0; i_instr_valid = 1'b1; i_dec_ready = 1'b0;
        i_instr = 32'h002081B3; i_pc = 32'h0000_0040;
        step(); step();
        n_chk++; if (o_dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", o_dec_valid); end
        n_chk++; if (o_instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", o_instr_ready); end
        n_chk++; if (o_alu_operator !== 5'd0) begin n_fail++; $display("FAIL reset_alu: got %0d want 0", o_alu_operator); end
        n_chk++; if (o_imm !== 32'h0) begin n_fail++; $display("FAIL reset_imm: got %h want 0", o_imm); end
        n_chk++; if (o_rd_addr !== 5'd0 || o_rd_we !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %0d/%0b want 0/0", o_rd_addr, o_rd_we); end
        n_chk++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", o_pc); end
        i_rst = 1'b0; i_instr_valid = 1'b0;
        step();
    endtask

    task automatic test_add();
        i_dec_ready = 1'b1; i_instr_valid = 1'b1; i_instr = 32'h002081B3; i_pc = 32'h0000_0100;
        #1;
        n_chk++; if (o_dec_valid !== 1'b0) begin n_fail++; $display("FAIL add_pre_valid: got %0b want 0", o_dec_valid); end
        step();
        i_instr_valid = 1'b0;
        n_chk++; if (o_dec_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %0b want 1", o_dec_valid); end
        n_chk++; if (o_alu_operator !== ALU_ADD) begin n_fail++; $display("FAIL add_alu: got %0d want %0d", o_alu_operator, ALU_ADD); end
        n_chk++; if (o_rs1_addr !== 5'd1 || o_rs2_addr !== 5'd2 || o_rd_addr !== 5'd3) begin n_fail++; $display("FAIL add_regs: got %0d,%0d,%0d want 1,2,3", o_rs1_addr, o_rs2_addr, o_rd_addr); end
        n_chk++; if (o_rd_we !== 1'b1 || o_op2_imm !== 1'b0 || o_op1_pc !== 1'b0) begin n_fail++; $display("FAIL add_flags: got we=%0b imm=%0b pc=%0b want 1,0,0", o_rd_we, o_op2_imm, o_op1_pc); end
        n_chk++; if (o_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL add_pc: got %h want 00000100", o_pc); end
        step();
        n_chk++; if (o_dec_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %0b want 0", o_dec_valid); end
    endtask

    task automatic test_back_to_back();
        i_dec_ready = 1'b1; i_instr_valid = 1'b1; i_instr = 32'hFFF00093; i_pc = 32'h0000_0200;
        step();
        n_chk++; if (o_dec_valid !== 1'b1 || o_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm: got v=%0b imm=%h want 1 ffffffff", o_dec_valid, o_imm); end
        n_chk++; if (o_alu_operator !== ALU_ADD || o_op2_imm !== 1'b1 || o_illegal !== 1'b0) begin n_fail++; $display("FAIL addi_op: got alu=%0d imm=%0b ill=%0b want %0d 1 0", o_alu_operator, o_op2_imm, o_illegal, ALU_ADD); end
        n_chk++; if (o_instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0b want 1", o_instr_ready); end
        i_instr = 32'h40335293; i_pc = 32'h0000_0204;
        step();
        i_instr_valid = 1'b0;
        n_chk++; if (o_dec_valid !== 1'b1 || o_pc !== 32'h0000_0204) begin n_fail++; $display("FAIL srai_valid: got v=%0b pc=%h want 1 00000204", o_dec_valid, o_pc); end
        n_chk++; if (o_alu_operator !== ALU_LSR_SIGN) begin n_fail++; $display("FAIL srai_alu: got %0d want %0d", o_alu_operator, ALU_LSR_SIGN); end
        n_chk++; if (o_imm[4:0] !== 5'd3 || o_rs1_addr !== 5'd6 || o_rd_addr !== 5'd5) begin n_fail++; $display("FAIL srai_fields: got sh=%0d rs1=%0d rd=%0d want 3 6 5", o_imm[4:0], o_rs1_addr, o_rd_addr); end
        step();
        n_chk++; if (o_dec_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0b want 0", o_dec_valid); end
    endtask

    task automatic test_branch_lui();
        i_dec_ready = 1'b1; i_instr_valid = 1'b1; i_instr = 32'h00208463; i_pc = 32'h0000_0300;
        step();
        n_chk++; if (o_alu_operator !== ALU_BR_EQ || o_imm !== 32'd8) begin n_fail++; $display("FAIL beq_op: got alu=%0d imm=%h want %0d 8", o_alu_operator, o_imm, ALU_BR_EQ); end
        n_chk++; if (o_branch !== 1'b1 || o_rd_we !== 1'b0 || o_op2_imm !== 1'b0) begin n_fail++; $display("FAIL beq_flags: got br=%0b we=%0b imm=%0b want 1 0 0", o_branch, o_rd_we, o_op2_imm); end
        i_instr = 32'h123453B7; i_pc = 32'h0000_0304;
        step();
        i_instr_valid = 1'b0;
        n_chk++; if (o_alu_operator !== ALU_PASSTHROUGH_RS2 || o_imm !== 32'h12345000) begin n_fail++; $display("FAIL lui_op: got alu=%0d imm=%h want %0d 12345000", o_alu_operator, o_imm, ALU_PASSTHROUGH_RS2); end
        n_chk++; if (o_op2_imm !== 1'b1 || o_rd_we !== 1'b1 || o_rd_addr !== 5'd7 || o_branch !== 1'b0) begin n_fail++; $display("FAIL lui_flags: got imm=%0b we=%0b rd=%0d br=%0b want 1 1 7 0", o_op2_imm, o_rd_we, o_rd_addr, o_branch); end
        step();
    endtask

    task automatic test_jal_rd0();
        i_dec_ready = 1'b1; i_instr_valid = 1'b1; i_instr = 32'h010000EF; i_pc = 32'h0000_0500;
        step();
        n_chk++; if (o_jump !== 1'b1 || o_op1_pc !== 1'b1 || o_rd_we !== 1'b1 || o_alu_operator !== ALU_ADD) begin n_fail++; $display("FAIL jal_flags: got j=%0b pc=%0b we=%0b alu=%0d want 1 1 1 0", o_jump, o_op1_pc, o_rd_we, o_alu_operator); end
        n_chk++; if (o_imm !== 32'd16) begin n_fail++; $display("FAIL jal_imm: got %h want 10", o_imm); end
        i_instr = 32'h00000013;
        step();
        i_instr_valid = 1'b0;
        n_chk++; if (o_rd_we !== 1'b0 || o_illegal !== 1'b0 || o_jump !== 1'b0) begin n_fail++; $display("FAIL rd0_we: got we=%0b ill=%0b j=%0b want 0 0 0", o_rd_we, o_illegal, o_jump); end
        step();
    endtask

    task automatic test_backpressure();
        i_dec_ready = 1'b0; i_instr_valid = 1'b1; i_instr = 32'h00C12203; i_pc = 32'h0000_0400;
        step();
        n_chk++; if (o_dec_valid !== 1'b1 || o_mem_rd !== 1'b1 || o_imm !== 32'd12 || o_funct3 !== 3'b010) begin n_fail++; $display("FAIL lw_fields: got v=%0b rd=%0b imm=%h f3=%0d want 1 1 c 2", o_dec_valid, o_mem_rd, o_imm, o_funct3); end
        i_instr = 32'h0050A423; i_pc = 32'h0000_0404;
        for (int c = 0; c < 3; c++) begin
            n_chk++; if (o_instr_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %0b want 0", c, o_instr_ready); end
            step();
            n_chk++; if (o_dec_valid !== 1'b1 || o_imm !== 32'd12 || o_pc !== 32'h0000_0400 || o_mem_rd !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%0b imm=%h pc=%h want 1 c 00000400", c, o_dec_valid, o_imm, o_pc); end
        end
        i_dec_ready = 1'b1;
        #1;
        n_chk++; if (o_instr_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %0b want 1", o_instr_ready); end
        step();
        i_instr_valid = 1'b0;
        n_chk++; if (o_dec_valid !== 1'b1 || o_mem_wr !== 1'b1 || o_mem_rd !== 1'b0 || o_rd_we !== 1'b0) begin n_fail++; $display("FAIL sw_flags: got v=%0b wr=%0b rd=%0b we=%0b want 1 1 0 0", o_dec_valid, o_mem_wr, o_mem_rd, o_rd_we); end
        n_chk++; if (o_imm !== 32'd8 || o_pc !== 32'h0000_0404 || o_rs2_addr !== 5'd5) begin n_fail++; $display("FAIL sw_fields: got imm=%h pc=%h rs2=%0d want 8 00000404 5", o_imm, o_pc, o_rs2_addr); end
        step();
        n_chk++; if (o_dec_valid !== 1'b0) begin n_fail++; $display("FAIL sw_drain: got %0b want 0", o_dec_valid); end
    endtask

    task automatic test_flush();
        i_dec_ready = 1'b0; i_instr_valid = 1'b1; i_instr = 32'h002081B3; i_pc = 32'h0000_0600;
        step();
        i_dec_ready = 1'b1; i_flush = 1'b1; i_instr = 32'h123453B7; i_pc = 32'h0000_0604;
        step();
        i_flush = 1'b0; i_instr_valid = 1'b0;
        n_chk++; if (o_dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b want 0", o_dec_valid); end
        step();
        n_chk++; if (o_dec_valid !== 1'b0 || o_instr_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after: got v=%0b r=%0b want 0 1", o_dec_valid, o_instr_ready); end
    endtask

    task automatic test_illegal();
        i_dec_ready = 1'b1; i_instr_valid = 1'b1; i_instr = 32'hFFFFFFFF; i_pc = 32'h0000_0700;
        step();
        n_chk++; if (o_illegal !== 1'b1 || o_alu_operator !== ALU_PASSTHROUGH_RS1) begin n_fail++; $display("FAIL ill_op: got ill=%0b alu=%0d want 1 %0d", o_illegal, o_alu_operator, ALU_PASSTHROUGH_RS1); end
        n_chk++; if ({o_rd_we, o_mem_rd, o_mem_wr, o_branch, o_jump} !== 5'b0) begin n_fail++; $display("FAIL ill_flags: got %b want 00000", {o_rd_we, o_mem_rd, o_mem_wr, o_branch, o_jump}); end
        i_instr = 32'h0020A463;
        step();
        i_instr_valid = 1'b0;
        n_chk++; if (o_illegal !== 1'b1 || o_branch !== 1'b0 || o_alu_operator !== ALU_PASSTHROUGH_RS1) begin n_fail++; $display("FAIL ill_br010: got ill=%0b br=%0b alu=%0d want 1 0 %0d", o_illegal, o_branch, o_alu_operator, ALU_PASSTHROUGH_RS1); end
        step();
    endtask

    task automatic test_rst_stall();
        i_dec_ready = 1'b0; i_instr_valid = 1'b1; i_instr = 32'h00C12203; i_pc = 32'h0000_0800;
        step();
        i_rst = 1'b1; i_flush = 1'b1; i_instr = 32'h002081B3;
        step();
        i_rst = 1'b0; i_flush = 1'b0; i_instr_valid = 1'b0;
        n_chk++; if (o_dec_valid !== 1'b0 || o_instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got v=%0b r=%0b want 0 1", o_dec_valid, o_instr_ready); end
        n_chk++; if (o_imm !== 32'h0 || o_mem_rd !== 1'b0 || o_pc !== 32'h0) begin n_fail++; $display("FAIL rst_clear: got imm=%h rd=%0b pc=%h want 0 0 0", o_imm, o_mem_rd, o_pc); end
        step();
    endtask

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_instr_valid = 1'b0; i_dec_ready = 1'b0;
        i_instr = '0; i_pc = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_branch_lui();
        test_jal_rd0();
        test_backpressure();
        test_flush();
        test_illegal();
        test_rst_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
